// File: rtl/noc_net_interface.sv
// NoC network interface: PE valid/ready ports bridged to 2-phase
// bundled-data router links, with a TX FIFO and a single-entry RX register.
module noc_net_interface #(
    parameter int         WIDTH_PACKAGE = 50,
    parameter logic [3:0] NODE_LOC      = 4'b00_00,
    parameter int         FIFO_DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     pe_tx_valid,
    output logic                     pe_tx_ready,
    input  logic [3:0]               pe_tx_dest,
    input  logic [1:0]               pe_tx_type,
    input  logic [31:0]              pe_tx_data,
    output logic                     link_tx_req,
    output logic [WIDTH_PACKAGE-1:0] link_tx_data,
    input  logic                     link_tx_ack,
    input  logic                     link_rx_req,
    input  logic [WIDTH_PACKAGE-1:0] link_rx_data,
    output logic                     link_rx_ack,
    output logic                     pe_rx_valid,
    input  logic                     pe_rx_ready,
    output logic [3:0]               pe_rx_src,
    output logic [1:0]               pe_rx_type,
    output logic [7:0]               pe_rx_seq,
    output logic [31:0]              pe_rx_data,
    output logic                     rx_misroute
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [3:0]  dest;
        logic [3:0]  src;
        logic [1:0]  ptype;
        logic [7:0]  seq;
        logic [31:0] data;
    } pkt_t;

    typedef enum logic {
        TX_IDLE,
        TX_WAIT_ACK
    } tx_state_t;

    logic [WIDTH_PACKAGE-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]            wr_ptr;
    logic [AW-1:0]            rd_ptr;
    logic [CW-1:0]            count;
    logic [7:0]               seq_cnt;
    logic                     rdy_en;
    logic                     push;
    logic                     pop;
    logic                     tx_load;
    tx_state_t                tx_state;
    tx_state_t                tx_next;
    logic                     tx_ack_s1;
    logic                     tx_ack_s2;

    // Ready stays low until the first edge after reset release
    assign pe_tx_ready = rdy_en && (count < CW'(FIFO_DEPTH));
    assign push        = pe_tx_valid && pe_tx_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            seq_cnt <= '0;
            rdy_en  <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            if (push) begin
                fifo_mem[wr_ptr] <= {pe_tx_dest, NODE_LOC, pe_tx_type,
                                     seq_cnt, pe_tx_data};
                wr_ptr  <= wr_ptr + 1'b1;
                seq_cnt <= seq_cnt + 8'd1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_ack_s1 <= 1'b0;
            tx_ack_s2 <= 1'b0;
        end else begin
            tx_ack_s1 <= link_tx_ack;
            tx_ack_s2 <= tx_ack_s1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tx_state <= TX_IDLE;
        else        tx_state <= tx_next;
    end

    always_comb begin
        tx_next = tx_state;
        tx_load = 1'b0;
        pop     = 1'b0;
        unique case (tx_state)
            TX_IDLE: begin
                if (count != '0) begin
                    tx_load = 1'b1;
                    tx_next = TX_WAIT_ACK;
                end
            end
            TX_WAIT_ACK: begin
                if (tx_ack_s2 == link_tx_req) begin
                    pop     = 1'b1;
                    tx_next = TX_IDLE;
                end
            end
        endcase
    end

    // Data is loaded together with the req toggle and held until the pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            link_tx_req  <= 1'b0;
            link_tx_data <= '0;
        end else if (tx_load) begin
            link_tx_req  <= ~link_tx_req;
            link_tx_data <= fifo_mem[rd_ptr];
        end
    end

    logic rx_req_s1;
    logic rx_req_s2;
    logic rx_pending;
    logic rx_capture;
    logic rx_drain;
    logic rx_to_me;
    pkt_t rx_pkt;

    assign rx_pkt     = pkt_t'(link_rx_data);
    assign rx_to_me   = (rx_pkt.dest == NODE_LOC);
    assign rx_pending = (rx_req_s2 != link_rx_ack);
    assign rx_drain   = pe_rx_valid && pe_rx_ready;
    assign rx_capture = rx_pending && (!pe_rx_valid || pe_rx_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_req_s1 <= 1'b0;
            rx_req_s2 <= 1'b0;
        end else begin
            rx_req_s1 <= link_rx_req;
            rx_req_s2 <= rx_req_s1;
        end
    end

    // Misrouted packets are acknowledged and dropped, leaving a sticky flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            link_rx_ack <= 1'b0;
            pe_rx_valid <= 1'b0;
            pe_rx_src   <= '0;
            pe_rx_type  <= '0;
            pe_rx_seq   <= '0;
            pe_rx_data  <= '0;
            rx_misroute <= 1'b0;
        end else begin
            if (rx_capture) link_rx_ack <= ~link_rx_ack;
            if (rx_capture && rx_to_me) begin
                pe_rx_valid <= 1'b1;
                pe_rx_src   <= rx_pkt.src;
                pe_rx_type  <= rx_pkt.ptype;
                pe_rx_seq   <= rx_pkt.seq;
                pe_rx_data  <= rx_pkt.data;
            end else if (rx_drain) begin
                pe_rx_valid <= 1'b0;
            end
            if (rx_capture && !rx_to_me) rx_misroute <= 1'b1;
        end
    end

endmodule

// File: tb/tb_noc_net_interface.sv
// Bench for noc_net_interface: queue-based transaction model, directed
// scenarios and randomized traffic on both links.
module tb_noc_net_interface;

    localparam logic [3:0] LOC   = 4'b0101;
    localparam int         DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        pe_tx_valid;
    logic        pe_tx_ready;
    logic [3:0]  pe_tx_dest;
    logic [1:0]  pe_tx_type;
    logic [31:0] pe_tx_data;
    logic        link_tx_req;
    logic [49:0] link_tx_data;
    logic        link_tx_ack;
    logic        link_rx_req;
    logic [49:0] link_rx_data;
    logic        link_rx_ack;
    logic        pe_rx_valid;
    logic        pe_rx_ready;
    logic [3:0]  pe_rx_src;
    logic [1:0]  pe_rx_type;
    logic [7:0]  pe_rx_seq;
    logic [31:0] pe_rx_data;
    logic        rx_misroute;

    noc_net_interface #(
        .WIDTH_PACKAGE(50),
        .NODE_LOC     (LOC),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pe_tx_valid (pe_tx_valid),
        .pe_tx_ready (pe_tx_ready),
        .pe_tx_dest  (pe_tx_dest),
        .pe_tx_type  (pe_tx_type),
        .pe_tx_data  (pe_tx_data),
        .link_tx_req (link_tx_req),
        .link_tx_data(link_tx_data),
        .link_tx_ack (link_tx_ack),
        .link_rx_req (link_rx_req),
        .link_rx_data(link_rx_data),
        .link_rx_ack (link_rx_ack),
        .pe_rx_valid (pe_rx_valid),
        .pe_rx_ready (pe_rx_ready),
        .pe_rx_src   (pe_rx_src),
        .pe_rx_type  (pe_rx_type),
        .pe_rx_seq   (pe_rx_seq),
        .pe_rx_data  (pe_rx_data),
        .rx_misroute (rx_misroute)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Transaction-level model
    logic [49:0] m_q[$];
    bit          m_busy;
    logic        m_req;
    logic [49:0] m_tx_data;
    logic        m_tx_h1, m_tx_h2;
    logic [7:0]  m_seq;
    bit          m_rdy_en;
    bit          m_push;
    logic        m_rx_h1, m_rx_h2;
    logic        m_rx_ack;
    logic        m_valid;
    logic        m_mis;
    logic [3:0]  m_src;
    logic [1:0]  m_type;
    logic [7:0]  m_rseq;
    logic [31:0] m_rdata;
    bit          m_cap;
    bit          m_drain;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_busy   = 0;
            m_req    = 0;
            m_tx_data = '0;
            m_tx_h1  = 0;
            m_tx_h2  = 0;
            m_seq    = 0;
            m_rdy_en = 0;
            m_rx_h1  = 0;
            m_rx_h2  = 0;
            m_rx_ack = 0;
            m_valid  = 0;
            m_mis    = 0;
            m_src    = 0;
            m_type   = 0;
            m_rseq   = 0;
            m_rdata  = 0;
        end else begin
            m_push = pe_tx_valid && m_rdy_en && (m_q.size() < DEPTH);
            if (!m_busy) begin
                if (m_q.size() > 0) begin
                    m_tx_data = m_q[0];
                    m_req     = ~m_req;
                    m_busy    = 1;
                end
            end else if (m_tx_h2 == m_req) begin
                void'(m_q.pop_front());
                m_busy = 0;
            end
            if (m_push) begin
                m_q.push_back({pe_tx_dest, LOC, pe_tx_type, m_seq, pe_tx_data});
                m_seq = m_seq + 8'd1;
            end
            m_tx_h2  = m_tx_h1;
            m_tx_h1  = link_tx_ack;
            m_rdy_en = 1;

            m_drain = m_valid && pe_rx_ready;
            m_cap   = (m_rx_h2 != m_rx_ack) && (!m_valid || pe_rx_ready);
            if (m_cap) begin
                m_rx_ack = ~m_rx_ack;
                if (link_rx_data[49:46] == LOC) begin
                    m_valid = 1;
                    m_src   = link_rx_data[45:42];
                    m_type  = link_rx_data[41:40];
                    m_rseq  = link_rx_data[39:32];
                    m_rdata = link_rx_data[31:0];
                end else begin
                    m_mis = 1;
                    if (m_drain) m_valid = 0;
                end
            end else if (m_drain) begin
                m_valid = 0;
            end
            m_rx_h2 = m_rx_h1;
            m_rx_h1 = link_rx_req;
        end
    end

    logic       prev_req_mon = 1'b0;
    logic [7:0] last_seq     = 8'h00;
    bit         wrap_seen    = 0;
    int         n_sent       = 0;

    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            chk("pe_tx_ready", 64'(pe_tx_ready),
                64'(m_rdy_en && (m_q.size() < DEPTH)));
            chk("link_tx_req", 64'(link_tx_req), 64'(m_req));
            chk("link_tx_data", 64'(link_tx_data), 64'(m_tx_data));
            chk("link_rx_ack", 64'(link_rx_ack), 64'(m_rx_ack));
            chk("pe_rx_valid", 64'(pe_rx_valid), 64'(m_valid));
            chk("pe_rx_src", 64'(pe_rx_src), 64'(m_src));
            chk("pe_rx_type", 64'(pe_rx_type), 64'(m_type));
            chk("pe_rx_seq", 64'(pe_rx_seq), 64'(m_rseq));
            chk("pe_rx_data", 64'(pe_rx_data), 64'(m_rdata));
            chk("rx_misroute", 64'(rx_misroute), 64'(m_mis));
            if (link_tx_req !== prev_req_mon) begin
                if (last_seq == 8'hFF && link_tx_data[39:32] == 8'h00)
                    wrap_seen = 1;
                last_seq = link_tx_data[39:32];
                n_sent++;
            end
            prev_req_mon = link_tx_req;
        end else begin
            prev_req_mon = 1'b0;
        end
    end

    int ack_mode = 0;
    bit rand_tx  = 0;
    bit rand_rx  = 0;

    task automatic tick();
        @(negedge clk);
        if (!rst_n) begin
            link_tx_ack = 1'b0;
            link_rx_req = 1'b0;
        end else begin
            case (ack_mode)
                1: link_tx_ack = link_tx_req;
                2: if ($urandom_range(0, 2) == 0) link_tx_ack = link_tx_req;
                default: ;
            endcase
            if (rand_tx) begin
                pe_tx_valid = 1'($urandom_range(0, 1));
                pe_tx_dest  = 4'($urandom);
                pe_tx_type  = 2'($urandom);
                pe_tx_data  = $urandom;
            end
            if (rand_rx) begin
                pe_rx_ready = ($urandom_range(0, 3) != 0);
                if (link_rx_req == link_rx_ack && $urandom_range(0, 3) == 0) begin
                    link_rx_data = {($urandom_range(0, 3) == 0) ? 4'($urandom) : LOC,
                                    4'($urandom), 2'($urandom), 8'($urandom),
                                    32'($urandom)};
                    link_rx_req = ~link_rx_req;
                end
            end
        end
    endtask

    task automatic push_one(input logic [3:0] d, input logic [1:0] t,
                            input logic [31:0] x);
        logic r;
        pe_tx_dest  = d;
        pe_tx_type  = t;
        pe_tx_data  = x;
        pe_tx_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            r = pe_tx_ready;
            tick();
            if (r) return;
        end
        n_cmp++;
        n_err++;
        $display("FAIL push_timeout: got no acceptance within 200 cycles");
    endtask

    int n;
    int base;

    initial begin
        rst_n        = 1'b0;
        pe_tx_valid  = 1'b0;
        pe_tx_dest   = '0;
        pe_tx_type   = '0;
        pe_tx_data   = '0;
        link_tx_ack  = 1'b0;
        link_rx_req  = 1'b0;
        link_rx_data = '0;
        pe_rx_ready  = 1'b0;

        repeat (3) tick();
        chk("rst_tx_ready", 64'(pe_tx_ready), 64'd0);
        chk("rst_tx_req", 64'(link_tx_req), 64'd0);
        rst_n = 1'b1;
        tick();
        chk("ready_after_release", 64'(pe_tx_ready), 64'd1);
        chk("rst_rx_valid", 64'(pe_rx_valid), 64'd0);

        // First send: literal packet image and one-cycle latency
        pe_tx_dest  = 4'hC;
        pe_tx_type  = 2'd2;
        pe_tx_data  = 32'hDEADBEEF;
        pe_tx_valid = 1'b1;
        tick();
        chk("req_at_accept", 64'(link_tx_req), 64'd0);
        pe_tx_valid = 1'b0;
        tick();
        chk("req_toggled", 64'(link_tx_req), 64'd1);
        chk("tx_packet_image", 64'(link_tx_data), 64'h31600DEADBEEF);

        // Reset while waiting for ack with three packets held
        push_one(4'h1, 2'd0, 32'h1);
        push_one(4'h2, 2'd1, 32'h2);
        pe_tx_valid = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_req", 64'(link_tx_req), 64'd0);
        chk("midrst_data", 64'(link_tx_data), 64'd0);
        chk("midrst_ready", 64'(pe_tx_ready), 64'd0);
        chk("midrst_rx_ack", 64'(link_rx_ack), 64'd0);
        tick();
        rst_n = 1'b1;
        repeat (10) tick();
        chk("no_send_after_reset", 64'(link_tx_req), 64'd0);

        // Fill FIFO with ack stalled, then release one entry
        for (int i = 0; i < 4; i++) push_one(4'(i), 2'd1, 32'(i));
        pe_tx_valid = 1'b0;
        chk("full_ready", 64'(pe_tx_ready), 64'd0);
        chk("first_seq", 64'(link_tx_data[39:32]), 64'd0);
        link_tx_ack = ~link_tx_ack;
        n = 0;
        do begin
            tick();
            n++;
        end while (!pe_tx_ready && n < 10);
        chk("ready_return_cycles", 64'(n), 64'd3);
        tick();
        chk("second_seq", 64'(link_tx_data[39:32]), 64'd1);
        chk("second_req", 64'(link_tx_req), 64'd0);
        ack_mode = 1;
        repeat (20) tick();

        // Sequence wrap with immediate acknowledge
        base = n_sent;
        for (int i = 0; i < 257; i++)
            push_one(4'($urandom), 2'($urandom), $urandom);
        pe_tx_valid = 1'b0;
        repeat (40) tick();
        chk("sent_257", 64'(n_sent - base), 64'd257);
        chk("seq_wrap_seen", 64'(wrap_seen), 64'd1);
        chk("last_seq", 64'(last_seq), 64'h04);

        // RX backpressure then back-to-back capture
        pe_rx_ready  = 1'b0;
        link_rx_data = {LOC, 4'hA, 2'd1, 8'h11, 32'h12345678};
        link_rx_req  = 1'b1;
        repeat (3) tick();
        chk("rx1_valid", 64'(pe_rx_valid), 64'd1);
        chk("rx1_ack", 64'(link_rx_ack), 64'd1);
        chk("rx1_src", 64'(pe_rx_src), 64'hA);
        chk("rx1_data", 64'(pe_rx_data), 64'h12345678);
        link_rx_data = {LOC, 4'h3, 2'd2, 8'h22, 32'hCAFEF00D};
        link_rx_req  = 1'b0;
        repeat (6) tick();
        chk("rx2_held_ack", 64'(link_rx_ack), 64'd1);
        chk("rx2_held_data", 64'(pe_rx_data), 64'h12345678);
        pe_rx_ready = 1'b1;
        tick();
        chk("rx2_valid", 64'(pe_rx_valid), 64'd1);
        chk("rx2_data", 64'(pe_rx_data), 64'hCAFEF00D);
        chk("rx2_seq", 64'(pe_rx_seq), 64'h22);
        chk("rx2_ack", 64'(link_rx_ack), 64'd0);
        tick();
        chk("rx2_drained", 64'(pe_rx_valid), 64'd0);

        // Misrouted packet
        chk("mis_before", 64'(rx_misroute), 64'd0);
        link_rx_data = {4'h0, 4'h9, 2'd3, 8'h33, 32'h0BADF00D};
        link_rx_req  = 1'b1;
        repeat (4) tick();
        chk("mis_ack", 64'(link_rx_ack), 64'd1);
        chk("mis_valid", 64'(pe_rx_valid), 64'd0);
        chk("mis_flag", 64'(rx_misroute), 64'd1);
        repeat (10) tick();
        chk("mis_sticky", 64'(rx_misroute), 64'd1);

        // Randomized concurrent traffic, with a reset in the middle
        ack_mode = 2;
        rand_tx  = 1;
        rand_rx  = 1;
        repeat (1500) tick();
        rst_n = 1'b0;
        #1;
        chk("rst2_misroute", 64'(rx_misroute), 64'd0);
        chk("rst2_rx_valid", 64'(pe_rx_valid), 64'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (1500) tick();
        rand_tx     = 0;
        rand_rx     = 0;
        pe_tx_valid = 1'b0;
        pe_rx_ready = 1'b1;
        ack_mode    = 1;
        repeat (50) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
